// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file types and constants.
// Address, data width and counter sizing used across the regfile slice.
package regfile_scoreboard_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 2;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: one saturating counter per register.
// Issue increments, writeback decrements, flush clears everything.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rstf,
    input  logic          we,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic             w_inc [NREGS];
    logic             w_dec [NREGS];
    logic [CNT_W-1:0] w_c1;
    logic [CNT_W-1:0] w_c2;
    logic             w_ret1;
    logic             w_ret2;

    // A retiring write in this cycle frees a slot, so it unblocks a saturated issue.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_we && issue_rd != '0 && r_cnt[issue_rd] == CNT_MAX &&
            !(we && rd == issue_rd))
            issue_ready = 1'b0;
    end

    // Busy reflects the counter after any same-cycle retire, matching the bypass.
    always_comb begin
        w_c1     = r_cnt[rs1_addr];
        w_c2     = r_cnt[rs2_addr];
        w_ret1   = we && rd == rs1_addr && w_c1 != '0;
        w_ret2   = we && rd == rs2_addr && w_c2 != '0;
        rs1_busy = rs1_addr != '0 && (w_c1 - CNT_W'(w_ret1)) != '0;
        rs2_busy = rs2_addr != '0 && (w_c2 - CNT_W'(w_ret2)) != '0;
    end

    // Per-register increment/decrement requests; decrement never underflows.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_inc[r] = issue_valid && issue_ready && issue_we &&
                       issue_rd == AW'(r) && r != 0;
            w_dec[r] = we && rd == AW'(r) && r_cnt[r] != '0 && r != 0;
        end
    end

    // Counter array update; flush wins over any inc/dec in the same cycle.
    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            for (int r = 0; r < NREGS; r++)
                r_cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NREGS; r++)
                r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                else if (w_dec[r] && !w_inc[r])
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through read ports and a
// pending-write scoreboard for RAW hazard detection in decode.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN  = regfile_scoreboard_pkg::XLEN,
    parameter int NREGS = regfile_scoreboard_pkg::NREGS,
    parameter int CNT_W = regfile_scoreboard_pkg::CNT_W,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rstf,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rdValue,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            flush
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

    // Storage write; x0 is hardwired to zero so writes to it are dropped.
    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            for (int r = 0; r < NREGS; r++)
                r_regs[r] <= '0;
        end else if (we && rd != '0) begin
            r_regs[rd] <= rdValue;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        w_rs1 = r_regs[rs1_addr];
        w_rs2 = r_regs[rs2_addr];
        if (we && rd != '0 && rd == rs1_addr)
            w_rs1 = rdValue;
        if (we && rd != '0 && rd == rs2_addr)
            w_rs2 = rdValue;
        if (rs1_addr == '0)
            w_rs1 = '0;
        if (rs2_addr == '0)
            w_rs2 = '0;
    end

    assign rs1_data = w_rs1;
    assign rs2_data = w_rs2;

    reg_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rstf        (rstf),
        .we          (we),
        .rd          (rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rstf;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rdValue;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs1_busy;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        rs2_busy;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clk         (clk),
        .rstf        (rstf),
        .we          (we),
        .rd          (rd),
        .rdValue     (rdValue),
        .rs1_addr    (rs1_addr),
        .rs1_data    (rs1_data),
        .rs1_busy    (rs1_busy),
        .rs2_addr    (rs2_addr),
        .rs2_data    (rs2_data),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; rd = 0; rdValue = 0;
        issue_valid = 0; issue_we = 0; issue_rd = 0;
        flush = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1; issue_we = 1; issue_rd = r;
    endtask

    task automatic test_reset();
        idle();
        rs1_addr = 5; rs2_addr = 0;
        rstf = 1;
        tick(); tick();
        rstf = 0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs1_data got=%h exp=%h", rs1_data, 32'h0);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs2_data got=%h exp=%h", rs2_data, 32'h0);
        end
        checks++;
        if (rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rs1_busy got=%b exp=0", rs1_busy);
        end
        checks++;
        if (rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rs2_busy got=%b exp=0", rs2_busy);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", issue_ready);
        end
    endtask

    task automatic test_bypass();
        tick();
        we = 1; rd = 7; rdValue = 32'hDEADBEEF; rs1_addr = 7;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_same got=%h exp=%h", rs1_data, 32'hDEADBEEF);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_stored got=%h exp=%h", rs1_data, 32'hDEADBEEF);
        end
        checks++;
        if (rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL bypass_busy got=%b exp=0", rs1_busy);
        end
    endtask

    task automatic test_x0();
        we = 1; rd = 0; rdValue = 32'h1234; rs2_addr = 0;
        #1;
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_bypass got=%h exp=0", rs2_data);
        end
        tick();
        idle();
        issue(0);
        #1;
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_stored got=%h exp=0", rs2_data);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready got=%b exp=1", issue_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL x0_busy got=%b exp=0", rs2_busy);
        end
    endtask

    task automatic test_raw();
        issue(3);
        rs1_addr = 3;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL raw_pre_busy got=%b exp=0", rs1_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL raw_busy got=%b exp=1", rs1_busy);
        end
        we = 1; rd = 3; rdValue = 32'h55;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL raw_retire_busy got=%b exp=0", rs1_busy);
        end
        checks++;
        if (rs1_data !== 32'h55) begin
            failures++;
            $display("FAIL raw_retire_data got=%h exp=%h", rs1_data, 32'h55);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'h55) begin
            failures++;
            $display("FAIL raw_after busy=%b data=%h exp busy=0 data=55",
                     rs1_busy, rs1_data);
        end
    endtask

    task automatic test_saturation();
        rs1_addr = 9;
        issue(9);
        tick(); tick(); tick();
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_ready got=%b exp=0", issue_ready);
        end
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_busy got=%b exp=1", rs1_busy);
        end
        tick();
        we = 1; rd = 9; rdValue = 32'h99;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_retire_ready got=%b exp=1", issue_ready);
        end
        tick();
        we = 0;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_still_full got=%b exp=0", issue_ready);
        end
        idle();
        we = 1; rd = 9; rdValue = 32'h91;
        tick(); tick();
        we = 0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_one_left got=%b exp=1", rs1_busy);
        end
        we = 1; rdValue = 32'h92;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL sat_last_retire got=%b exp=0", rs1_busy);
        end
        tick();
        rdValue = 32'h93;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'h93) begin
            failures++;
            $display("FAIL sat_underflow busy=%b data=%h exp busy=0 data=93",
                     rs1_busy, rs1_data);
        end
        issue(9);
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_reissue got=%b exp=1", rs1_busy);
        end
        we = 1; rd = 9; rdValue = 32'h94;
        tick();
        idle();
    endtask

    task automatic test_flush();
        rs2_addr = 4;
        issue(4);
        tick(); tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre_busy got=%b exp=1", rs2_busy);
        end
        flush = 1; we = 1; rd = 4; rdValue = 32'hA;
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle_busy got=%b exp=1", rs2_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b0 || rs2_data !== 32'hA) begin
            failures++;
            $display("FAIL flush_after busy=%b data=%h exp busy=0 data=a",
                     rs2_busy, rs2_data);
        end
        issue(4);
        flush = 1;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_vs_issue got=%b exp=0", rs2_busy);
        end
    endtask

    task automatic test_async_reset();
        rs1_addr = 10;
        we = 1; rd = 10; rdValue = 32'h77;
        issue(10);
        tick();
        idle();
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_data !== 32'h77) begin
            failures++;
            $display("FAIL areset_pre busy=%b data=%h exp busy=1 data=77",
                     rs1_busy, rs1_data);
        end
        #1;
        rstf = 1;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== 32'h0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset busy=%b data=%h ready=%b exp 0/0/1",
                     rs1_busy, rs1_data, issue_ready);
        end
        tick();
        rstf = 0;
    endtask

    initial begin
        rs1_addr = 0; rs2_addr = 0;
        rstf = 1;
        idle();
        test_reset();
        test_bypass();
        test_x0();
        test_raw();
        test_saturation();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
